// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Receive-side monitor for a 6-digit multiplexed 7-segment bus. It samples the
//   digit enables, the segments and the decimal point, and waits for each digit to
//   hold steady for SETTLE cycles. It then decodes the glyph back to BCD. When all
//   six digits have been captured, it publishes them as one frame.
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   i_seg_enb    digit enables, active-low one-hot, bit5 = leftmost digit
//   i_seg_dp     decimal point of the active digit
//   i_seg        segments {a,b,c,d,e,f,g}, active-high
//   o_digits     last complete frame, nibble per digit, [23:20] = enb bit5
//   o_dp         last complete frame's dp bits, same order as i_seg_enb
//   o_valid      1-cycle pulse when o_digits/o_dp take a new frame
//   o_err_enb    pulse: more than one enable low in a sampled cycle
//   o_err_seg    pulse: a digit was captured with an illegal glyph
//   o_stale      level: no frame completed within TIMEOUT cycles
module seg_scan_decoder #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  i_seg_enb,
  input  logic        i_seg_dp,
  input  logic [6:0]  i_seg,
  output logic [23:0] o_digits,
  output logic [5:0]  o_dp,
  output logic        o_valid,
  output logic        o_err_enb,
  output logic        o_err_seg,
  output logic        o_stale
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {TRACK, CAPTURE, LOCKED} state_t;

  // S1 input registers; every decision below looks only at these.
  logic [5:0]       r_enb;
  logic [6:0]       r_seg;
  logic             r_dp;
  logic [13:0]      r_prev;   // S1 bundle from the previous cycle
  logic [13:0]      r_lock;   // bundle that was captured in the current dwell
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [5:0]       r_mask;
  logic [5:0][3:0]  r_shadow;
  logic [5:0]       r_shdp;
  logic [2:0]       r_cap_idx;
  logic [3:0]       r_cap_nib;
  logic             r_cap_dp;
  logic             r_cap_bad;
  logic [TW-1:0]    r_to;

  logic [13:0]      w_cur;
  logic [5:0]       w_low;
  logic             w_one;
  logic             w_multi;
  logic [2:0]       w_idx;
  logic [4:0]       w_dec;

  assign w_cur   = {r_enb, r_seg, r_dp};
  assign w_low   = ~r_enb;
  // Clearing the lowest set bit leaves a nonzero value only when two or more bits are set.
  assign w_multi = (w_low & (w_low - 6'd1)) != 6'd0;
  assign w_one   = (w_low != 6'd0) && !w_multi;

  always_comb begin
    w_idx = 3'd0;
    for (int i = 0; i < 6; i++)
      if (!r_enb[i]) w_idx = 3'(i);
  end

  // {illegal, nibble}; a blank glyph is the digit B and is legal.
  always_comb begin
    case (r_seg)
      7'h7E:   w_dec = 5'h00;
      7'h30:   w_dec = 5'h01;
      7'h6D:   w_dec = 5'h02;
      7'h79:   w_dec = 5'h03;
      7'h33:   w_dec = 5'h04;
      7'h5B:   w_dec = 5'h05;
      7'h5F:   w_dec = 5'h06;
      7'h70:   w_dec = 5'h07;
      7'h7F:   w_dec = 5'h08;
      7'h7B:   w_dec = 5'h09;
      7'h00:   w_dec = 5'h0B;
      default: w_dec = 5'h1F;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enb     <= 6'h3F;
      r_seg     <= '0;
      r_dp      <= 1'b0;
      r_prev    <= {6'h3F, 8'h00};
      r_lock    <= '0;
      r_state   <= TRACK;
      r_cnt     <= '0;
      r_mask    <= '0;
      r_shadow  <= '0;
      r_shdp    <= '0;
      r_cap_idx <= '0;
      r_cap_nib <= '0;
      r_cap_dp  <= 1'b0;
      r_cap_bad <= 1'b0;
      r_to      <= '0;
      o_digits  <= '0;
      o_dp      <= '0;
      o_valid   <= 1'b0;
      o_err_enb <= 1'b0;
      o_err_seg <= 1'b0;
      o_stale   <= 1'b0;
    end else begin
      r_enb     <= i_seg_enb;
      r_seg     <= i_seg;
      r_dp      <= i_seg_dp;
      r_prev    <= w_cur;
      o_err_enb <= w_multi;
      o_err_seg <= 1'b0;
      o_valid   <= 1'b0;

      // The mask can only be full in the cycle right after a CAPTURE, so clearing it here
      // never collides with another capture.
      if (r_mask == 6'h3F) begin
        o_digits <= r_shadow;
        o_dp     <= r_shdp;
        o_valid  <= 1'b1;
        r_mask   <= '0;
        r_to     <= '0;
        o_stale  <= 1'b0;
      end else begin
        if (r_to != TW'(TIMEOUT)) r_to <= r_to + 1'b1;
        if (r_to >= TW'(TIMEOUT - 1)) o_stale <= 1'b1;
      end

      case (r_state)
        TRACK: begin
          if (!w_one || w_cur != r_prev) begin
            r_cnt <= '0;
          end else if (r_cnt == CW'(SETTLE - 1)) begin
            // Latch the dwell now, so that an enable change during CAPTURE
            // cannot corrupt the write.
            r_state   <= CAPTURE;
            r_lock    <= w_cur;
            r_cap_idx <= w_idx;
            r_cap_nib <= w_dec[3:0];
            r_cap_bad <= w_dec[4];
            r_cap_dp  <= r_dp;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        CAPTURE: begin
          r_shadow[r_cap_idx] <= r_cap_nib;
          r_shdp[r_cap_idx]   <= r_cap_dp;
          r_mask[r_cap_idx]   <= 1'b1;
          o_err_seg           <= r_cap_bad;
          r_cnt               <= '0;
          r_state             <= LOCKED;
        end
        LOCKED: begin
          // Compare against the captured bundle, not the previous cycle, so that a
          // change that arrives during CAPTURE still ends the dwell.
          if (w_cur != r_lock) begin
            r_cnt   <= '0;
            r_state <= TRACK;
          end
        end
        default: r_state <= TRACK;
      endcase
    end
  end

endmodule
